// File: rtl/apb_master_mc.sv
// Multi-channel APB3 master fed by a command FIFO. Each command runs one read or
// write on a selected channel; read data and error words go to a response FIFO.
module apb_master_mc #(
  parameter int              NCH      = 4,
  parameter int              AW       = 24,
  parameter int              DW       = 32,
  parameter int              TMO      = 255,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_empty,
  output logic                o_rdata_en,
  input  logic [31:0]         i_rdata,
  input  logic                i_full,
  output logic                o_wdata_vld,
  output logic [DW-1:0]       o_wdata,
  output logic [NCH-1:0]      o_psel,
  output logic                o_penable,
  output logic                o_pwrite,
  output logic [AW-1:0]       o_paddr,
  output logic [DW-1:0]       o_pwdata,
  input  logic [NCH*DW-1:0]   i_prdata,
  input  logic [NCH-1:0]      i_pready,
  input  logic [NCH-1:0]      i_pslverr,
  output logic                o_err_vld,
  output logic [1:0]          o_err_code
);

  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DREQ, S_DCAP, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_run;
  logic [3:0]      r_ch;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [DW-1:0]   r_resp;
  logic [TW-1:0]   r_tmo;
  logic            r_err_vld;
  logic [1:0]      r_err_code;

  logic            w_cmd_ok;
  logic            w_sel_rdy;
  logic            w_sel_err;
  logic [DW-1:0]   w_sel_prd;
  logic            w_timeout;
  logic            w_apb_act;
  logic            w_rdata_en;
  logic            w_wdata_vld;

  always_comb begin
    w_cmd_ok = i_rdata[2] && (int'(i_rdata[7:4]) < NCH);
  end

  always_comb begin
    w_sel_rdy = 1'b0;
    w_sel_err = 1'b0;
    w_sel_prd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == 4'(i)) begin
        w_sel_rdy = i_pready[i];
        w_sel_err = i_pslverr[i];
        w_sel_prd = i_prdata[i*DW +: DW];
      end
    end
  end

  // Fires on the ACCESS cycle that brings the wait count up to TMO.
  assign w_timeout = (r_tmo == TW'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rdata_en   = 1'b0;
    w_wdata_vld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_run && !i_empty) begin
          w_rdata_en   = 1'b1;
          w_state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (!w_cmd_ok)       w_state_next = S_IDLE;
        else if (i_rdata[0]) w_state_next = S_DREQ;
        else                 w_state_next = S_SETUP;
      end
      S_DREQ: begin
        if (!i_empty) begin
          w_rdata_en   = 1'b1;
          w_state_next = S_DCAP;
        end
      end
      S_DCAP:  w_state_next = S_SETUP;
      S_SETUP: w_state_next = S_ACCESS;
      S_ACCESS: begin
        if (w_sel_rdy || w_timeout) begin
          w_state_next = r_pwrite ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (!i_full) begin
          w_wdata_vld  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_ch       <= '0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_resp     <= '0;
      r_tmo      <= '0;
      r_err_vld  <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_run     <= 1'b1;
      r_err_vld <= 1'b0;
      case (r_state)
        S_CMD: begin
          if (!w_cmd_ok) begin
            r_err_vld  <= 1'b1;
            r_err_code <= 2'b11;
          end else begin
            r_paddr  <= i_rdata[8 +: AW];
            r_pwrite <= i_rdata[0];
            r_ch     <= i_rdata[7:4];
          end
        end
        S_DCAP:  r_pwdata <= i_rdata[DW-1:0];
        S_SETUP: r_tmo    <= '0;
        S_ACCESS: begin
          if (w_sel_rdy) begin
            if (!r_pwrite) r_resp <= w_sel_err ? ERR_DATA : w_sel_prd;
            if (w_sel_err) begin
              r_err_vld  <= 1'b1;
              r_err_code <= 2'b01;
            end
          end else if (w_timeout) begin
            if (!r_pwrite) r_resp <= ERR_DATA;
            r_err_vld  <= 1'b1;
            r_err_code <= 2'b10;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_apb_act = (r_state == S_SETUP) || (r_state == S_ACCESS);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_psel
    assign o_psel[gi] = w_apb_act && (r_ch == 4'(gi));
  end

  assign o_penable   = (r_state == S_ACCESS);
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_rdata_en  = w_rdata_en;
  assign o_wdata_vld = w_wdata_vld;
  assign o_wdata     = r_resp;
  assign o_err_vld   = r_err_vld;
  assign o_err_code  = r_err_code;

endmodule

// File: doc/apb_master_mc.md
Name: apb_master_mc

Overview:
- Parametrised, multi-channel successor of the command-FIFO-driven APB master.
- Pops 32-bit command words from an upstream command FIFO and runs one APB3 read or write on one of NCH slave channels.
- Pushes read data into a downstream response FIFO.
- Adds write support, PSLVERR capture, a per-transfer timeout and error reporting.

Parameters:
- NCH, 4, number of APB slave channels (1..16).
- AW, 24, APB address width (≤24, taken from command word bits [31:8]).
- DW, 32, APB data width.
- TMO, 255, max ACCESS cycles waiting for pready before timeout (≥1).
- ERR_DATA, 32'hDEAD_BEEF, word pushed on errored or timed-out reads.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- empty  in  1  command FIFO empty.
- rdata_en  out  1  command FIFO pop strobe.
- rdata  in  32  command FIFO data, valid the cycle after rdata_en.
- full  in  1  response FIFO full.
- wdata_vld  out  1  response FIFO push strobe.
- wdata  out  DW  response data.
- psel  out  NCH  one-hot select.
- penable  out  1  shared enable.
- pwrite  out  1  shared direction.
- paddr  out  AW  shared address.
- pwdata  out  DW  shared write data.
- prdata  in  NCH*DW  per-channel read data; channel i is bits [i*DW +: DW].
- pready  in  NCH  per-channel ready.
- pslverr  in  NCH  per-channel error.
- err_vld  out  1  one-cycle error pulse.
- err_code  out  2  01 = pslverr, 10 = timeout, 11 = bad command; held until the next err_vld.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (psel, penable, pwrite, paddr, pwdata, rdata_en, wdata_vld, wdata, err_vld, err_code); timeout counter 0.
- Command word: addr = rdata[31:8] truncated to AW.
  - ctrl = rdata[7:0]: ctrl[0] = write, ctrl[2] = valid, ctrl[7:4] = channel index. ctrl[3] and ctrl[1] are ignored.
- A write command is followed by a second FIFO word carrying pwdata.
- IDLE: if !empty, assert rdata_en for exactly one cycle, go to CMD. rdata_en is never asserted while empty=1.
- CMD: latch rdata.
  - If ctrl[2]=0 or channel ≥ NCH: err_vld=1, err_code=11, return to IDLE. Command dropped, no APB activity.
  - Else, write: go to DREQ.
  - Else, read: go to SETUP.
- DREQ: wait for !empty, pulse rdata_en, go to DCAP.
- DCAP: latch rdata[DW-1:0] into pwdata, go to SETUP.
- SETUP: one cycle with psel[ch]=1, penable=0, and paddr/pwrite/pwdata valid. Go to ACCESS. Timeout counter cleared.
- ACCESS: psel[ch]=1, penable=1. paddr, pwrite and pwdata stay stable.
  - pready of other channels is ignored.
  - On pready[ch]=1: drop psel and penable next cycle. Capture prdata[ch] and pslverr[ch].
    - If pslverr: err_vld=1, err_code=01.
    - Read: go to RESP with data = pslverr ? ERR_DATA : prdata[ch].
    - Write: go to IDLE.
  - Counter increments each ACCESS cycle without pready. When it reaches TMO:
    - Deassert psel/penable, err_vld=1, err_code=10.
    - Read: RESP with ERR_DATA. Write: IDLE.
- RESP: while full=1, hold data, wdata_vld=0. When full=0, wdata_vld=1 for one cycle with wdata = data, then go to IDLE.
- Latency, read with zero-wait slave, empty=0 and full=0: rdata_en at cycle 0, SETUP at cycle 2, ACCESS at cycle 3, wdata_vld at cycle 4.
- Minimum command-to-command gap: the next rdata_en cannot occur before the cycle after return to IDLE.
- Only one transfer is outstanding. psel is always one-hot or zero. penable=1 implies psel≠0.
- Reset mid-transfer: all APB outputs drop asynchronously. Any partially fetched command is discarded, and the upstream FIFO word already popped is lost.

Test Plan:
- Read ch0: empty 1→0, rdata={24'h000004,8'h04}, ch0 pready=1 with prdata=32'h8 on the second APB cycle → paddr=4, psel=0001, single wdata_vld with wdata=32'h8.
- Write ch2: words {24'h000010,8'h25} then 32'hA5A5_0001, pready after 3 wait cycles → psel=0100, pwrite=1, pwdata=32'hA5A5_0001 stable through ACCESS, no wdata_vld.
- Slave error: read ch1 with pready=1 and pslverr=1 → err_vld pulse, err_code=01, wdata=ERR_DATA.
- Timeout: TMO=8, read ch3, pready never asserted → ACCESS for exactly 8 cycles, err_code=10, wdata=ERR_DATA, psel returns to 0.
- Backpressure and bad command: full=1 for 5 cycles during RESP → wdata_vld held off, then one push. Command 8'h00 or channel 4 with NCH=4 → err_code=11, no psel.
- Reset mid-ACCESS: rst_n low during penable=1 → psel, penable and wdata_vld are 0 immediately. After release, a fresh read completes normally.
